pc_predict_unit: RTL and testbench

//  Fetch-stage PC generator with stall, execute-stage redirect and a direct-mapped

---
 rtl/pc_pkg.sv | 31 +++
 rtl/pc_predict_unit_btb_table.sv | 60 ++++++
 rtl/pc_predict_unit.sv | 82 ++++++++
 tb/tb_pc_predict_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage PC predictor: 2-bit branch counter
// encoding and its saturating step functions.
package pc_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  localparam bp_ctr_t CTR_RESET = WNT;
  localparam bp_ctr_t CTR_ALLOC = WT;

  function automatic bp_ctr_t sat_inc(input bp_ctr_t c);
    case (c)
      SNT:     return WNT;
      WNT:     return WT;
      default: return ST;
    endcase
  endfunction

  function automatic bp_ctr_t sat_dec(input bp_ctr_t c);
    case (c)
      ST:      return WT;
      WT:      return WNT;
      default: return SNT;
    endcase
  endfunction

endpackage

// File: rtl/pc_predict_unit_btb_table.sv
// Direct-mapped BTB storage: combinational lookup port and a clocked training port.
// Only valid/ctr are reset; valid gates the uninitialised tag/target storage.
module btb_table
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BTB_DEPTH  = 16,
  localparam int IDX_W     = $clog2(BTB_DEPTH),
  localparam int TAG_W     = DATA_WIDTH - IDX_W - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output bp_ctr_t               rd_ctr,
  output logic [DATA_WIDTH-1:0] rd_target,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic                  wr_taken,
  input  logic [DATA_WIDTH-1:0] wr_target
);

  logic [BTB_DEPTH-1:0]  valid_q;
  bp_ctr_t               ctr_q    [BTB_DEPTH];
  logic [TAG_W-1:0]      tag_q    [BTB_DEPTH];
  logic [DATA_WIDTH-1:0] target_q [BTB_DEPTH];
  logic                  wr_hit;

  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_ctr    = ctr_q[rd_idx];
  assign rd_target = target_q[rd_idx];

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) ctr_q[i] <= CTR_RESET;
    end else if (wr_en) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= wr_taken ? sat_inc(ctr_q[wr_idx]) : sat_dec(ctr_q[wr_idx]);
      end else if (wr_taken) begin
        valid_q[wr_idx] <= 1'b1;
        ctr_q[wr_idx]   <= CTR_ALLOC;
      end
    end
  end

  // A taken outcome either refreshes a hit entry's target or allocates over the occupant.
  always_ff @(posedge clk) begin
    if (rst && wr_en && wr_taken) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-stage PC generator: PC register, next-PC priority mux, incrementer and
// BTB-based taken/target prediction; execute trains the BTB and redirects.
module pc_predict_unit
  import pc_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    BTB_DEPTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           PC_INC     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_f,
  input  logic                  upd_valid,
  input  logic [DATA_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [DATA_WIDTH-1:0] upd_target,
  input  logic                  upd_mispredict,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] inc_PC,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_target
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

  logic [IDX_W-1:0]      idx_f;
  logic [TAG_W-1:0]      tag_f;
  logic [IDX_W-1:0]      idx_e;
  logic [TAG_W-1:0]      tag_e;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  bp_ctr_t               rd_ctr;
  logic [DATA_WIDTH-1:0] rd_target;
  logic                  lkp_hit;
  logic [DATA_WIDTH-1:0] pc_nxt;

  // Word-aligned PCs: bits [1:0] never take part in index or tag.
  assign idx_f = IDX_W'(PC >> 2);
  assign tag_f = TAG_W'(PC >> (IDX_W + 2));
  assign idx_e = IDX_W'(upd_pc >> 2);
  assign tag_e = TAG_W'(upd_pc >> (IDX_W + 2));

  btb_table #(
    .DATA_WIDTH (DATA_WIDTH),
    .BTB_DEPTH  (BTB_DEPTH)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (idx_f),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_ctr    (rd_ctr),
    .rd_target (rd_target),
    .wr_en     (upd_valid),
    .wr_idx    (idx_e),
    .wr_tag    (tag_e),
    .wr_taken  (upd_taken),
    .wr_target (upd_target)
  );

  assign lkp_hit     = rd_valid && (rd_tag == tag_f);
  assign pred_taken  = lkp_hit && ((rd_ctr == WT) || (rd_ctr == ST));
  assign pred_target = pred_taken ? rd_target : '0;
  assign inc_PC      = PC + DATA_WIDTH'(PC_INC);

  // Flush beats stall; prediction only steers a fetch that is actually advancing.
  always_comb begin
    pc_nxt = inc_PC;
    if (upd_mispredict) pc_nxt = redirect_pc;
    else if (!en_f)     pc_nxt = PC;
    else if (pred_taken) pc_nxt = pred_target;
  end

  always_ff @(posedge clk) begin
    if (!rst) PC <= RESET_PC;
    else      PC <= pc_nxt;
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit: per-cycle vector table plus a hand-written
// counter saturation sequence.
module tb_pc_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_f;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] PC;
  logic [31:0] inc_PC;
  logic        pred_taken;
  logic [31:0] pred_target;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_predict_unit #(
    .DATA_WIDTH (32),
    .BTB_DEPTH  (16),
    .RESET_PC   (32'h0),
    .PC_INC     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en_f           (en_f),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .redirect_pc    (redirect_pc),
    .PC             (PC),
    .inc_PC         (inc_PC),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utg;
    logic        mp;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic [31:0] e_inc;
    logic        e_pt;
    logic [31:0] e_ptg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic en, input logic uv,
                              input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                              input logic mp, input logic [31:0] rpc,
                              input logic [31:0] e_pc, input logic [31:0] e_inc,
                              input logic e_pt, input logic [31:0] e_ptg);
    vec_t v;
    v.rst = r; v.en = en; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg;
    v.mp = mp; v.rpc = rpc; v.e_pc = e_pc; v.e_inc = e_inc; v.e_pt = e_pt; v.e_ptg = e_ptg;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utg, input logic mp,
                       input logic [31:0] rpc);
    rst = r; en_f = en; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utg; upd_mispredict = mp; redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input int idx, input logic [31:0] e_pc, input logic [31:0] e_inc,
                            input logic e_pt, input logic [31:0] e_ptg);
    chk("PC", idx, PC, e_pc);
    chk("inc_PC", idx, inc_PC, e_inc);
    chk("pred_taken", idx, {31'b0, pred_taken}, {31'b0, e_pt});
    chk("pred_target", idx, pred_target, e_ptg);
  endtask

  initial begin
    rst = 1'b0; en_f = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_mispredict = 1'b0; redirect_pc = '0;

    //          rst en uv upc          ut utg          mp rpc           PC           inc          pt ptg
    // reset and sequential fetch
    tbl.push_back(mk(0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h0,       32'h4,       0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h4,       32'h8,       0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h8,       32'hC,       0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'hC,       32'h10,      0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h10,      32'h14,      0, 32'h0));
    // stall three cycles, then release
    tbl.push_back(mk(1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h10,      32'h14,      0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h10,      32'h14,      0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h10,      32'h14,      0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h14,      32'h18,      0, 32'h0));
    // mid-run reset beats a simultaneous redirect
    tbl.push_back(mk(0, 1, 0, 32'h0,     0, 32'h0,     1, 32'h100,      32'h0,       32'h4,       0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h4,       32'h8,       0, 32'h0));
    // allocate 0x20 -> 0x80 while stalled, redirect to it, follow prediction
    tbl.push_back(mk(1, 0, 1, 32'h20,    1, 32'h80,    0, 32'h0,        32'h4,       32'h8,       0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h0,     0, 32'h0,     1, 32'h20,       32'h20,      32'h24,      1, 32'h80));
    tbl.push_back(mk(1, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h80,      32'h84,      0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h84,      32'h88,      0, 32'h0));
    // two not-taken: WT -> WNT -> SNT; fetch 0x20 goes sequential
    tbl.push_back(mk(1, 0, 1, 32'h20,    0, 32'h0,     0, 32'h0,        32'h84,      32'h88,      0, 32'h0));
    tbl.push_back(mk(1, 0, 1, 32'h20,    0, 32'h0,     0, 32'h0,        32'h84,      32'h88,      0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h0,     0, 32'h0,     1, 32'h20,       32'h20,      32'h24,      0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h24,      32'h28,      0, 32'h0));
    // stays SNT, then two taken to predict again (second one retargets to 0x90)
    tbl.push_back(mk(1, 0, 1, 32'h20,    0, 32'h0,     0, 32'h0,        32'h24,      32'h28,      0, 32'h0));
    tbl.push_back(mk(1, 0, 1, 32'h20,    1, 32'h80,    0, 32'h0,        32'h24,      32'h28,      0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h0,     0, 32'h0,     1, 32'h20,       32'h20,      32'h24,      0, 32'h0));
    tbl.push_back(mk(1, 0, 1, 32'h20,    1, 32'h90,    0, 32'h0,        32'h20,      32'h24,      1, 32'h90));
    // redirect beats stall and the live prediction
    tbl.push_back(mk(1, 0, 0, 32'h0,     0, 32'h0,     1, 32'h100,      32'h100,     32'h104,     0, 32'h0));
    // same-cycle train and lookup at 0x100: lookup sees old (miss) contents
    tbl.push_back(mk(1, 1, 1, 32'h100,   1, 32'h200,   0, 32'h0,        32'h104,     32'h108,     0, 32'h0));
    // alias 0x60 shares idx with 0x20: miss, then allocation evicts 0x20
    tbl.push_back(mk(1, 1, 0, 32'h0,     0, 32'h0,     1, 32'h60,       32'h60,      32'h64,      0, 32'h0));
    tbl.push_back(mk(1, 0, 1, 32'h60,    1, 32'hA0,    0, 32'h0,        32'h60,      32'h64,      1, 32'hA0));
    tbl.push_back(mk(1, 0, 0, 32'h0,     0, 32'h0,     1, 32'h20,       32'h20,      32'h24,      0, 32'h0));
    // wrap at the top of the address space
    tbl.push_back(mk(1, 0, 0, 32'h0,     0, 32'h0,     1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,    0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,        32'h0,       32'h4,       0, 32'h0));
    // reset clears BTB valid: trained 0x60 no longer predicts
    tbl.push_back(mk(0, 1, 0, 32'h0,     0, 32'h0,     1, 32'h100,      32'h0,       32'h4,       0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h0,     0, 32'h0,     1, 32'h60,       32'h60,      32'h64,      0, 32'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].uv, tbl[i].upc, tbl[i].ut, tbl[i].utg,
            tbl[i].mp, tbl[i].rpc);
      check_outs(i, tbl[i].e_pc, tbl[i].e_inc, tbl[i].e_pt, tbl[i].e_ptg);
    end

    // Saturation at ST: alloc WT, taken -> ST, taken stays ST, not-taken -> WT (still predicts).
    drive(1, 0, 1, 32'h40, 1, 32'h300, 0, 32'h0);
    drive(1, 0, 1, 32'h40, 1, 32'h300, 0, 32'h0);
    drive(1, 0, 1, 32'h40, 1, 32'h300, 0, 32'h0);
    drive(1, 0, 1, 32'h40, 0, 32'h0,   0, 32'h0);
    drive(1, 0, 0, 32'h0,  0, 32'h0,   1, 32'h40);
    check_outs(100, 32'h40, 32'h44, 1'b1, 32'h300);
    drive(1, 1, 0, 32'h0,  0, 32'h0,   0, 32'h0);
    check_outs(101, 32'h300, 32'h304, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
